hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Sequences stall, bubble, flush and freeze controls for the 5-stage MIPS pipeline.
- Combines three hazard sources under one FSM:
  - load-use hazard from ID/EX against IF/ID;
  - taken branch resolved in EX;
  - multi-cycle data-memory handshake in MEM.
- Drives the write-enable, flush and hold inputs of the PC, IF/ID, ID/EX and back-end pipe registers.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- LOAD_STALL_CYCLES, 1, number of cycles PC and IF/ID are held per load-use hazard (legal range 1-15).
- MEM_TIMEOUT, 64, number of consecutive MEM_WAIT cycles after which mem_timeout_o sets.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- idex_mem_read_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  5  destination register of the instruction in ID/EX.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- branch_taken_i  in  1  branch resolved taken in EX this cycle.
- dmem_req_i  in  1  MEM stage has an active load/store.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP (32'd0).
- idex_bubble_o  out  1  ID/EX control fields loaded as zero.
- pipe_hold_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0, saturating.
- flush_cnt_o  out  CNT_W  taken-branch flushes, saturating.
- mem_timeout_o  out  1  sticky: a memory wait exceeded MEM_TIMEOUT.

Behaviour:
- Reset:
  - One clock; rst_i is asynchronous and active-low.
  - While rst_i=0: state=RUN, lu_cnt=0, wait_cnt=0, stall_cnt_o=0, flush_cnt_o=0, mem_timeout_o=0.
  - Control outputs during reset: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, pipe_hold_o=0.
- Load-use hazard:
  - lu_haz = idex_mem_read_i & (idex_rt_i != 0) & (idex_rt_i == ifid_rs_i | idex_rt_i == ifid_rt_i).
  - $zero never causes a stall.
- Memory wait: mem_wait = dmem_req_i & ~dmem_ack_i.
- Control outputs are combinational from state and inputs. Default: pc_write_o=1, ifid_write_o=1, others 0.
- Priority in every state: mem_wait > branch_taken_i > lu_haz.
- State RUN:
  - mem_wait: pipe_hold_o=1, pc_write_o=0, ifid_write_o=0; next=MEM_WAIT, wait_cnt=1.
  - else branch_taken_i: ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1; flush_cnt +1; stay RUN. A simultaneous lu_haz is ignored, because its instruction is flushed.
  - else lu_haz: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
    - LOAD_STALL_CYCLES>1: next=LU_STALL, lu_cnt=LOAD_STALL_CYCLES-1.
    - LOAD_STALL_CYCLES=1: stay RUN.
- State LU_STALL:
  - Outputs as a load-use stall, independent of lu_haz (ID/EX already holds the bubble).
  - lu_cnt decrements each cycle; when lu_cnt==1, next=RUN.
  - mem_wait in this state: pipe_hold_o=1 additionally, lu_cnt frozen, state stays LU_STALL.
  - branch_taken_i in this state: flush as in RUN, abort the stall, next=RUN.
- State MEM_WAIT:
  - While mem_wait: pipe_hold_o=1, pc_write_o=0, ifid_write_o=0; wait_cnt increments, saturating at MEM_TIMEOUT.
  - If wait_cnt reaches MEM_TIMEOUT, mem_timeout_o sets; only reset clears it.
  - On dmem_ack_i, or dmem_req_i dropping: that cycle outputs revert to RUN rules (branch and lu_haz evaluated normally), wait_cnt=0, next=RUN.
- Latency: no added delay. Controls are valid in the same cycle the hazard inputs are valid, for the next rising edge.
- Counters:
  - stall_cnt_o +1 on every cycle with pc_write_o=0.
  - Both counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-wait: return immediately to reset values, with no residual hold.

Test Plan:
- Load-use: lw $2 in ID/EX (idex_mem_read_i=1, idex_rt_i=2), IF/ID rs=2 -> pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 for exactly 1 cycle; stall_cnt_o=1.
- Register 0: idex_rt_i=0 with ifid_rs_i=0, idex_mem_read_i=1 -> no stall; all defaults.
- Branch during hazard: branch_taken_i=1 and lu_haz=1 together -> ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1; flush_cnt_o=1, stall_cnt_o=0.
- Memory wait: dmem_req_i=1, ack after 5 cycles -> pipe_hold_o=1 for 5 cycles, released in the ack cycle; stall_cnt_o=5; mem_timeout_o=0.
- Timeout: MEM_TIMEOUT=8, ack withheld 20 cycles -> mem_timeout_o=1 from the 8th wait cycle, stays 1 after ack; cleared only by rst_i=0.
- Multi-cycle load-use with LOAD_STALL_CYCLES=3 and mem_wait during cycle 2 -> stall lasts 3 cycles plus the wait length; async reset mid-stall returns pc_write_o=1 immediately.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Stall / bubble / flush / freeze sequencer for the 5-stage pipeline.
// Arbitrates memory waits, taken branches and load-use hazards; keeps saturating perf counters.
module hazard_stall_controller #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 64,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_mem_read_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
    localparam logic [3:0] LuInit = 4'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        lu_cnt_q, lu_cnt_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              mem_timeout_q;

    logic lu_haz;
    logic mem_wait;
    logic use_run;
    logic flush_evt;

    assign lu_haz = idex_mem_read_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    assign mem_wait = dmem_req_i && !dmem_ack_i;

    // The cycle that leaves MEM_WAIT is arbitrated exactly like a RUN cycle.
    assign use_run = (state_q == StRun) || ((state_q == StMemWait) && !mem_wait);

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        flush_evt     = 1'b0;

        unique case (state_q)
            StRun: ;
            StLuStall: begin
                if (mem_wait) begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_bubble_o = 1'b1;
                    pipe_hold_o   = 1'b1;
                end else if (branch_taken_i) begin
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                    flush_evt     = 1'b1;
                    lu_cnt_d      = 4'd0;
                    state_d       = StRun;
                end else begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_bubble_o = 1'b1;
                    lu_cnt_d      = lu_cnt_q - 4'd1;
                    if (lu_cnt_q <= 4'd1) begin
                        lu_cnt_d = 4'd0;
                        state_d  = StRun;
                    end
                end
            end
            StMemWait: begin
                if (mem_wait) begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    pipe_hold_o  = 1'b1;
                    if (wait_cnt_q != WaitMax) begin
                        wait_cnt_d = wait_cnt_q + WaitW'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                    state_d    = StRun;
                end
            end
            default: begin
                state_d    = StRun;
                lu_cnt_d   = 4'd0;
                wait_cnt_d = '0;
            end
        endcase

        if (use_run) begin
            if (mem_wait) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                pipe_hold_o  = 1'b1;
                wait_cnt_d   = WaitW'(1);
                state_d      = StMemWait;
            end else if (branch_taken_i) begin
                // A coincident load-use hazard is moot: its consumer is being flushed.
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
                flush_evt     = 1'b1;
            end else if (lu_haz) begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_bubble_o = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    lu_cnt_d = LuInit;
                    state_d  = StLuStall;
                end
            end
        end

        // No residual hold while reset is asserted, whatever the inputs say.
        if (!rst_i) begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
            pipe_hold_o   = 1'b0;
            flush_evt     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= StRun;
            lu_cnt_q      <= 4'd0;
            wait_cnt_q    <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            if (!pc_write_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (mem_wait && (wait_cnt_d == WaitMax)) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign mem_timeout_o = mem_timeout_q;

endmodule
